wishbone_slave_router: RTL and testbench
========================================

// Module: wishbone_slave_router
// PURPOSE
//  Parametrised Wishbone B4 classic address decoder/router that sits between the master arbiter and all
//  slaves (SRAM, GPIO, LA, team projects). It routes one transaction at a time to the slave selected by a
//  per-slave base/mask table and waits for that slave's real ack. It adds unmapped-address and
//  timeout error responses, plus abort on cycle drop.
// PARAMETERS
//  NUM_SLAVES      9                      number of slave ports (1..16)
//  DATA_W          32                     data bus width, multiple of 8
//  TIMEOUT_CYCLES  255                    BUSY cycles without ack before error; 0 = no timeout
//  SLAVE_BASE      {NUM_SLAVES x 32b}     slave k base = SLAVE_BASE[k*32+:32]; dflt 0x3300_0000,0x3200_0000,
//                                         0x3100_0000,0x3010_0000..0x3060_0000
//  SLAVE_MASK      {NUM_SLAVES x 32b}     address bits compared; dflt 0xFFFF_0000 x3, 0xFFF0_0000 x6
// PORTS
//  CLK               in   1                  system clock
//  RST               in   1                  async reset, active-high
//  wbs_cyc_i_m       in   1                  master cycle
//  wbs_stb_i_m       in   1                  master strobe
//  wbs_we_i_m        in   1                  master write enable
//  wbs_adr_i_m       in   32                 master address
//  wbs_dat_i_m       in   DATA_W             master write data
//  wbs_sel_i_m       in   DATA_W/8           master byte selects
//  wbs_ack_o_m       out  1                  ack to master, 1-cycle pulse
//  wbs_err_o_m       out  1                  error to master, 1-cycle pulse
//  wbs_dat_o_m       out  DATA_W             read data to master, valid with ack
//  wbs_cyc_o_periph  out  NUM_SLAVES         per-slave cycle
//  wbs_stb_o_periph  out  NUM_SLAVES         per-slave strobe
//  wbs_we_o_periph   out  NUM_SLAVES         per-slave write enable
//  wbs_adr_o_periph  out  NUM_SLAVES x 32    per-slave address
//  wbs_dat_o_periph  out  NUM_SLAVES x DATA_W  per-slave write data
//  wbs_sel_o_periph  out  NUM_SLAVES x DATA_W/8  per-slave byte selects
//  wbs_ack_i_periph  in   NUM_SLAVES         per-slave ack
//  wbs_dat_i_periph  in   NUM_SLAVES x DATA_W  per-slave read data
// BEHAVIOUR
//  - Reset (RST=1, async): state=IDLE; sel_idx=0; tmo_cnt=0; ack_o/err_o=0; dat_o=0; all periph outputs 0.
//  - Decode: hit[k] = ((adr & MASK[k]) == (BASE[k] & MASK[k])); lowest k wins on overlapping windows.
//  - FSM, states IDLE, BUSY, RESP, ERR:
//    IDLE: cyc&stb with hit -> latch sel_idx, clear tmo_cnt, go BUSY. cyc&stb with no hit -> ERR.
//          Nothing is forwarded while in IDLE.
//    BUSY: drive slave sel_idx combinationally with live master cyc/stb/we/adr/dat/sel; all other slaves 0.
//          ack_i_periph[sel_idx]=1 -> register ack_o=1, dat_o=dat_i_periph[sel_idx], go RESP.
//          Master cyc=0 -> abort, go IDLE, no ack or err.
//          TIMEOUT_CYCLES!=0 and tmo_cnt==TIMEOUT_CYCLES-1 with no ack -> go ERR.
//          Otherwise tmo_cnt++ (saturating width clog2(TIMEOUT_CYCLES+1)).
//    RESP: ack_o=1 for exactly this cycle; periph outputs all 0; go IDLE.
//    ERR:  err_o=1, dat_o=0 for exactly this cycle; periph outputs all 0; go IDLE.
//  - Latency: slave sees stb 1 cycle after the master's decode cycle. Master ack is 1 cycle after slave ack.
//    Minimum transaction = 3 cycles (IDLE, BUSY, RESP).
//  - ack_o and err_o are never high together. dat_o holds its value outside RESP; it is 0 after ERR.
//  - Acks from non-selected slaves, and acks seen in IDLE/RESP/ERR, are ignored.
//  - Master must drop stb on the cycle after ack/err. If stb stays high in IDLE, a new transaction is
//    decoded (back-to-back accesses are allowed).
//  - Reset mid-transaction: returns to IDLE immediately and drops all periph strobes asynchronously.
// TESTING
//  1 Read 0x3200_0004, GPIO acks in 2nd BUSY cycle with 0xA5A5_0001 -> stb_o_periph[1] high 2 cycles;
//    ack_o pulse with dat_o=0xA5A5_0001.
//  2 Write 0x3030_0010 dat 0x1234 sel 0xF -> only periph[5] sees we=1, dat=0x1234;
//    ack_o 1 cycle after slave ack.
//  3 Access 0x4000_0000 (unmapped) -> no periph strobe; err_o pulse 1 cycle after the request; dat_o=0.
//  4 TIMEOUT_CYCLES=4, SRAM never acks -> err_o after 4 BUSY cycles; stb_o_periph[0] deasserted in ERR.
//  5 Master drops cyc in BUSY, then slave acks -> no ack_o or err_o; FSM in IDLE.
//  6 RST pulsed while BUSY on slave 3 -> all periph outputs 0 immediately; ack_o=0; next access decodes.

Source files
------------

// File: rtl/wishbone_slave_router_if.sv
// Wishbone B4 classic bundle between the master arbiter, the router and its slave ports.
// Per-slave buses are flattened; slave k occupies slice [k*W +: W].
interface wishbone_slave_router_if #(
  parameter int unsigned NUM_SLAVES = 9,
  parameter int unsigned DATA_W     = 32
);
  localparam int unsigned SEL_W = DATA_W / 8;

  // master side
  logic                         wbs_cyc_i_m;
  logic                         wbs_stb_i_m;
  logic                         wbs_we_i_m;
  logic [31:0]                  wbs_adr_i_m;
  logic [DATA_W-1:0]            wbs_dat_i_m;
  logic [SEL_W-1:0]             wbs_sel_i_m;
  logic                         wbs_ack_o_m;
  logic                         wbs_err_o_m;
  logic [DATA_W-1:0]            wbs_dat_o_m;

  // peripheral side
  logic [NUM_SLAVES-1:0]        wbs_cyc_o_periph;
  logic [NUM_SLAVES-1:0]        wbs_stb_o_periph;
  logic [NUM_SLAVES-1:0]        wbs_we_o_periph;
  logic [NUM_SLAVES*32-1:0]     wbs_adr_o_periph;
  logic [NUM_SLAVES*DATA_W-1:0] wbs_dat_o_periph;
  logic [NUM_SLAVES*SEL_W-1:0]  wbs_sel_o_periph;
  logic [NUM_SLAVES-1:0]        wbs_ack_i_periph;
  logic [NUM_SLAVES*DATA_W-1:0] wbs_dat_i_periph;

  // router view
  modport slave (
    input  wbs_cyc_i_m, wbs_stb_i_m, wbs_we_i_m, wbs_adr_i_m, wbs_dat_i_m, wbs_sel_i_m,
    output wbs_ack_o_m, wbs_err_o_m, wbs_dat_o_m,
    output wbs_cyc_o_periph, wbs_stb_o_periph, wbs_we_o_periph,
    output wbs_adr_o_periph, wbs_dat_o_periph, wbs_sel_o_periph,
    input  wbs_ack_i_periph, wbs_dat_i_periph
  );

  // environment view (master arbiter plus slaves)
  modport master (
    output wbs_cyc_i_m, wbs_stb_i_m, wbs_we_i_m, wbs_adr_i_m, wbs_dat_i_m, wbs_sel_i_m,
    input  wbs_ack_o_m, wbs_err_o_m, wbs_dat_o_m,
    input  wbs_cyc_o_periph, wbs_stb_o_periph, wbs_we_o_periph,
    input  wbs_adr_o_periph, wbs_dat_o_periph, wbs_sel_o_periph,
    output wbs_ack_i_periph, wbs_dat_i_periph
  );
endinterface

// File: rtl/wishbone_slave_router.sv
// Wishbone B4 classic address decoder/router: one transaction at a time is forwarded to the
// slave selected by a base/mask table; unmapped addresses and silent slaves get an error
// response, and a dropped master cycle aborts the access without a response.
module wishbone_slave_router #(
  parameter int unsigned NUM_SLAVES     = 9,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE = {
    32'h3060_0000, 32'h3050_0000, 32'h3040_0000, 32'h3030_0000, 32'h3020_0000,
    32'h3010_0000, 32'h3100_0000, 32'h3200_0000, 32'h3300_0000},
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK = {
    32'hFFF0_0000, 32'hFFF0_0000, 32'hFFF0_0000, 32'hFFF0_0000, 32'hFFF0_0000,
    32'hFFF0_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000}
) (
  input logic                    CLK,
  input logic                    RST,
  wishbone_slave_router_if.slave bus
);

  localparam int unsigned SEL_W = DATA_W / 8;
  localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP,
    S_ERR
  } state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [IDX_W-1:0]             r_sel_idx;
  logic [TMO_W-1:0]             r_tmo_cnt;
  logic                         r_ack;
  logic                         r_err;
  logic [DATA_W-1:0]            r_dat;

  logic                         w_req;
  logic                         w_hit;
  logic [IDX_W-1:0]             w_hit_idx;
  logic                         w_sel_ack;
  logic [DATA_W-1:0]            w_sel_dat;

  logic [NUM_SLAVES-1:0]        w_cyc_o;
  logic [NUM_SLAVES-1:0]        w_stb_o;
  logic [NUM_SLAVES-1:0]        w_we_o;
  logic [NUM_SLAVES*32-1:0]     w_adr_o;
  logic [NUM_SLAVES*DATA_W-1:0] w_dat_o;
  logic [NUM_SLAVES*SEL_W-1:0]  w_sel_o;

  assign w_req = bus.wbs_cyc_i_m && bus.wbs_stb_i_m;

  // Address decode; scanning from the top down lets the lowest matching window win.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int unsigned k = NUM_SLAVES; k > 0; k--) begin
      if ((bus.wbs_adr_i_m & SLAVE_MASK[(k-1)*32 +: 32]) ==
          (SLAVE_BASE[(k-1)*32 +: 32] & SLAVE_MASK[(k-1)*32 +: 32])) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(k - 1);
      end
    end
  end

  // Pick the latched slave's ack and read data; other slaves' acks never reach the FSM.
  always_comb begin
    w_sel_ack = 1'b0;
    w_sel_dat = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (IDX_W'(k) == r_sel_idx) begin
        w_sel_ack = bus.wbs_ack_i_periph[k];
        w_sel_dat = bus.wbs_dat_i_periph[k*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state logic: ack beats abort, abort beats timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_state_nxt = w_hit ? S_BUSY : S_ERR;
        end
      end
      S_BUSY: begin
        if (w_sel_ack) begin
          w_state_nxt = S_RESP;
        end else if (!bus.wbs_cyc_i_m) begin
          w_state_nxt = S_IDLE;
        end else if ((TIMEOUT_CYCLES != 0) && (r_tmo_cnt == TMO_LAST)) begin
          w_state_nxt = S_ERR;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      S_ERR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, slave index, timeout counter and registered master response.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_sel_idx <= '0;
      r_tmo_cnt <= '0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_dat     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_IDLE) && (w_state_nxt == S_BUSY)) begin
        r_sel_idx <= w_hit_idx;
        r_tmo_cnt <= '0;
      end else if ((r_state == S_BUSY) && (w_state_nxt == S_BUSY) && (r_tmo_cnt != '1)) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
      r_ack <= (w_state_nxt == S_RESP);
      r_err <= (w_state_nxt == S_ERR);
      if (w_state_nxt == S_RESP) begin
        r_dat <= w_sel_dat;
      end else if (w_state_nxt == S_ERR) begin
        r_dat <= '0;
      end
    end
  end

  // Forward the live master bus to the selected slave only while BUSY; reset clears it at once.
  always_comb begin
    w_cyc_o = '0;
    w_stb_o = '0;
    w_we_o  = '0;
    w_adr_o = '0;
    w_dat_o = '0;
    w_sel_o = '0;
    if (r_state == S_BUSY) begin
      for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
        if (IDX_W'(k) == r_sel_idx) begin
          w_cyc_o[k]                    = bus.wbs_cyc_i_m;
          w_stb_o[k]                    = bus.wbs_stb_i_m;
          w_we_o[k]                     = bus.wbs_we_i_m;
          w_adr_o[k*32 +: 32]           = bus.wbs_adr_i_m;
          w_dat_o[k*DATA_W +: DATA_W]   = bus.wbs_dat_i_m;
          w_sel_o[k*SEL_W +: SEL_W]     = bus.wbs_sel_i_m;
        end
      end
    end
  end

  assign bus.wbs_ack_o_m      = r_ack;
  assign bus.wbs_err_o_m      = r_err;
  assign bus.wbs_dat_o_m      = r_dat;
  assign bus.wbs_cyc_o_periph = w_cyc_o;
  assign bus.wbs_stb_o_periph = w_stb_o;
  assign bus.wbs_we_o_periph  = w_we_o;
  assign bus.wbs_adr_o_periph = w_adr_o;
  assign bus.wbs_dat_o_periph = w_dat_o;
  assign bus.wbs_sel_o_periph = w_sel_o;

endmodule

// File: tb/tb_wishbone_slave_router.sv
// Directed bench for wishbone_slave_router: stimulus posts per-cycle expectations and
// queues expected master responses; an independent monitor compares at each negedge.
module tb_wishbone_slave_router;

  localparam int NS = 9;
  localparam int DW = 32;

  typedef logic [NS*32-1:0] w_t;
  typedef struct packed {
    logic        is_err;
    logic [31:0] dat;
  } resp_t;

  logic CLK;
  logic RST;

  wishbone_slave_router_if #(.NUM_SLAVES(NS), .DATA_W(DW)) bus();

  wishbone_slave_router #(
    .NUM_SLAVES    (NS),
    .DATA_W        (DW),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  resp_t   sb_q[$];
  int      n_checks;
  int      n_errors;

  logic    chk_en;
  logic    done;
  event    chk_ev;
  logic [NS-1:0] exp_pstb;
  logic [NS-1:0] exp_pwe;
  w_t      exp_padr;
  w_t      exp_pdat;
  logic    exp_ack;
  logic    exp_err;
  logic    exp_dat_chk;
  logic [31:0] exp_dat;

  function automatic w_t slot(input int k, input logic [31:0] v);
    w_t r;
    r = '0;
    if (k >= 0) r[k*32 +: 32] = v;
    return r;
  endfunction

  task automatic next_cycle();
    @(posedge CLK);
    #1;
    bus.wbs_ack_i_periph = '0;
    bus.wbs_dat_i_periph = '0;
    exp_dat_chk = 1'b0;
  endtask

  task automatic set_m(input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    bus.wbs_cyc_i_m = cyc;
    bus.wbs_stb_i_m = stb;
    bus.wbs_we_i_m  = we;
    bus.wbs_adr_i_m = adr;
    bus.wbs_dat_i_m = dat;
    bus.wbs_sel_i_m = sel;
  endtask

  // Expected peripheral view: slave k (or none for k<0) carries the current master request.
  task automatic exp_periph(input int k, input logic we);
    exp_pstb = (k >= 0) ? (NS'(1) << k) : '0;
    exp_pwe  = (k >= 0 && we) ? (NS'(1) << k) : '0;
    exp_padr = slot(k, bus.wbs_adr_i_m);
    exp_pdat = slot(k, bus.wbs_dat_i_m);
  endtask

  task automatic exp_resp(input logic ack, input logic err);
    exp_ack = ack;
    exp_err = err;
  endtask

  task automatic set_sack(input int k, input logic [31:0] dat);
    bus.wbs_ack_i_periph = NS'(1) << k;
    bus.wbs_dat_i_periph = slot(k, dat);
  endtask

  task automatic chk(input string nm, input w_t act, input w_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", nm, $time, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every ack/err and checks posted per-cycle expectations.
  initial begin
    resp_t e;
    forever begin
      @(negedge CLK or chk_ev);
      if (done) begin
        chk("sb_empty", w_t'(sb_q.size()), w_t'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
      end
      if (bus.wbs_ack_o_m || bus.wbs_err_o_m) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_resp", w_t'({bus.wbs_ack_o_m, bus.wbs_err_o_m}), w_t'(0));
        end else begin
          e = sb_q.pop_front();
          chk("resp_kind", w_t'({bus.wbs_ack_o_m, bus.wbs_err_o_m}), w_t'({~e.is_err, e.is_err}));
          chk("resp_dat", w_t'(bus.wbs_dat_o_m), w_t'(e.dat));
        end
      end
      if (chk_en) begin
        chk("pcyc", w_t'(bus.wbs_cyc_o_periph), w_t'(exp_pstb));
        chk("pstb", w_t'(bus.wbs_stb_o_periph), w_t'(exp_pstb));
        chk("pwe",  w_t'(bus.wbs_we_o_periph),  w_t'(exp_pwe));
        chk("padr", bus.wbs_adr_o_periph, exp_padr);
        chk("pdat", bus.wbs_dat_o_periph, exp_pdat);
        chk("ack",  w_t'(bus.wbs_ack_o_m), w_t'(exp_ack));
        chk("err",  w_t'(bus.wbs_err_o_m), w_t'(exp_err));
        if (exp_dat_chk) chk("dat_o", w_t'(bus.wbs_dat_o_m), w_t'(exp_dat));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    n_checks = 0;
    n_errors = 0;
    chk_en = 1'b0;
    done = 1'b0;
    exp_dat_chk = 1'b0;
    exp_dat = '0;
    RST = 1'b1;
    set_m(0, 0, 0, '0, '0, '0);
    bus.wbs_ack_i_periph = '0;
    bus.wbs_dat_i_periph = '0;
    exp_periph(-1, 0);
    exp_resp(0, 0);

    // reset state
    next_cycle();
    next_cycle();
    chk_en = 1'b1;
    exp_dat_chk = 1'b1; exp_dat = '0;
    next_cycle();
    RST = 1'b0;

    // 1: read GPIO, non-selected ack ignored, GPIO acks in 2nd BUSY cycle
    next_cycle(); set_m(1, 1, 0, 32'h3200_0004, 32'h0, 4'hF); exp_periph(-1, 0); exp_resp(0, 0);
    next_cycle(); set_sack(0, 32'h0BAD_0BAD); exp_periph(1, 0);
    next_cycle(); set_sack(1, 32'hA5A5_0001); sb_q.push_back({1'b0, 32'hA5A5_0001}); exp_periph(1, 0);
    next_cycle(); set_m(0, 0, 0, '0, '0, '0); exp_periph(-1, 0); exp_resp(1, 0);
    next_cycle(); exp_resp(0, 0); exp_dat_chk = 1'b1; exp_dat = 32'hA5A5_0001;

    // 2: write to slave 5, ack in first BUSY cycle
    next_cycle(); set_m(1, 1, 1, 32'h3030_0010, 32'h0000_1234, 4'hF); exp_periph(-1, 0);
    next_cycle(); set_sack(5, 32'hDEAD_BEEF); sb_q.push_back({1'b0, 32'hDEAD_BEEF}); exp_periph(5, 1);
    next_cycle(); set_m(0, 0, 0, '0, '0, '0); exp_periph(-1, 0); exp_resp(1, 0);
    next_cycle(); exp_resp(0, 0); exp_dat_chk = 1'b1; exp_dat = 32'hDEAD_BEEF;

    // 3: unmapped address
    next_cycle(); set_m(1, 1, 0, 32'h4000_0000, 32'h55, 4'hF); exp_periph(-1, 0);
    sb_q.push_back({1'b1, 32'h0});
    next_cycle(); exp_periph(-1, 0); exp_resp(0, 1);
    next_cycle(); set_m(0, 0, 0, '0, '0, '0); exp_resp(0, 0); exp_dat_chk = 1'b1; exp_dat = '0;

    // 4: SRAM never acks, timeout after 4 BUSY cycles
    next_cycle(); set_m(1, 1, 0, 32'h3300_0100, 32'h0, 4'hF); exp_periph(-1, 0);
    for (int i = 0; i < 4; i++) begin
      next_cycle(); exp_periph(0, 0); exp_resp(0, 0);
    end
    sb_q.push_back({1'b1, 32'h0});
    next_cycle(); exp_periph(-1, 0); exp_resp(0, 1);
    next_cycle(); set_m(0, 0, 0, '0, '0, '0); exp_resp(0, 0); exp_dat_chk = 1'b1; exp_dat = '0;

    // 5: master abort, late slave ack ignored
    next_cycle(); set_m(1, 1, 0, 32'h3100_0000, 32'h0, 4'hF); exp_periph(-1, 0);
    next_cycle(); exp_periph(2, 0);
    next_cycle(); set_m(0, 0, 0, '0, '0, '0); exp_periph(-1, 0); exp_resp(0, 0);
    next_cycle(); set_sack(2, 32'h0000_7777);
    next_cycle(); exp_resp(0, 0);

    // 6: reset while BUSY on slave 3, then a fresh access decodes
    next_cycle(); set_m(1, 1, 1, 32'h3010_0000, 32'h0000_CAFE, 4'hF); exp_periph(-1, 0);
    next_cycle(); exp_periph(3, 1);
    #6;
    RST = 1'b1;
    #1;
    exp_periph(-1, 0); exp_resp(0, 0);
    -> chk_ev;
    next_cycle(); RST = 1'b0; set_m(0, 0, 0, '0, '0, '0); exp_periph(-1, 0);
    exp_dat_chk = 1'b1; exp_dat = '0;
    next_cycle(); set_m(1, 1, 0, 32'h3010_0008, 32'h0, 4'hF); exp_periph(-1, 0);
    next_cycle(); set_sack(3, 32'h1357_9BDF); sb_q.push_back({1'b0, 32'h1357_9BDF}); exp_periph(3, 0);
    next_cycle(); set_m(0, 0, 0, '0, '0, '0); exp_periph(-1, 0); exp_resp(1, 0);
    next_cycle(); exp_resp(0, 0); exp_dat_chk = 1'b1; exp_dat = 32'h1357_9BDF;

    next_cycle();
    done = 1'b1;
  end

endmodule
